// File: rtl/sram_port_ctrl.sv
// Single-port asynchronous SRAM controller: one-entry request buffer feeding a
// write (setup/strobe/hold) and read (enable/capture) sequencer on a shared tri-state bus.
module sram_port_ctrl #(
  parameter int ADRX_W = 11,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic [ADRX_W-1:0] reqAdrx,
  input  logic [DATA_W-1:0] reqData,
  output logic              rspValid,
  output logic [DATA_W-1:0] rspData,
  output logic              wrDone,
  output logic [ADRX_W-1:0] sramAdrx,
  inout  wire  [DATA_W-1:0] sramData,
  output logic              sramNotOutEn,
  output logic              sramRead,
  output logic [15:0]       wrCount,
  output logic [15:0]       rdCount
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_SET  = 3'd1,
    S_WR_DO   = 3'd2,
    S_WR_HOLD = 3'd3,
    S_RD_EN   = 3'd4,
    S_RD_CAP  = 3'd5
  } state_t;

  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

  state_t              r_state;
  state_t              w_next;
  logic                r_buf_full;
  logic                r_buf_wr;
  logic [ADRX_W-1:0]   r_buf_adrx;
  logic [DATA_W-1:0]   r_buf_data;
  logic [ADRX_W-1:0]   r_adrx;
  logic [DATA_W-1:0]   r_wdata;
  logic [2:0]          r_lat_cnt;
  logic                r_drive;
  logic                r_oe_n;
  logic                r_sram_rd;
  logic                r_wr_done;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic [15:0]         r_wr_cnt;
  logic [15:0]         r_rd_cnt;
  logic                w_accept;
  logic                w_launch;

  assign w_accept = reqValid & ~r_buf_full;
  assign w_launch = (r_state == S_IDLE) & r_buf_full;

  // Next-state decode for the access sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_buf_full) begin
          w_next = r_buf_wr ? S_WR_SET : S_RD_EN;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WR_SET:  w_next = S_WR_DO;
      S_WR_DO:   w_next = S_WR_HOLD;
      S_WR_HOLD: w_next = S_IDLE;
      S_RD_EN: begin
        if (r_lat_cnt == LAT_LAST) begin
          w_next = S_RD_CAP;
        end else begin
          w_next = S_RD_EN;
        end
      end
      S_RD_CAP:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // State register and read-latency counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_lat_cnt <= 3'd0;
    end else begin
      r_state   <= w_next;
      r_lat_cnt <= (r_state == S_RD_EN) ? (r_lat_cnt + 3'd1) : 3'd0;
    end
  end

  // Request buffer; a load and a launch can never coincide since one needs it empty, the other full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf_full <= 1'b0;
      r_buf_wr   <= 1'b0;
      r_buf_adrx <= {ADRX_W{1'b0}};
      r_buf_data <= {DATA_W{1'b0}};
    end else if (w_accept) begin
      r_buf_full <= 1'b1;
      r_buf_wr   <= reqWrite;
      r_buf_adrx <= reqAdrx;
      r_buf_data <= reqData;
    end else if (w_launch) begin
      r_buf_full <= 1'b0;
    end
  end

  // Working address/data held for the whole access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_adrx  <= {ADRX_W{1'b0}};
      r_wdata <= {DATA_W{1'b0}};
    end else if (w_launch) begin
      r_adrx  <= r_buf_adrx;
      r_wdata <= r_buf_data;
    end
  end

  // SRAM controls registered from the next state so they change cleanly with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drive   <= 1'b0;
      r_oe_n    <= 1'b1;
      r_sram_rd <= 1'b1;
      r_wr_done <= 1'b0;
    end else begin
      r_drive   <= (w_next == S_WR_SET) || (w_next == S_WR_DO) || (w_next == S_WR_HOLD);
      r_oe_n    <= !((w_next == S_RD_EN) || (w_next == S_RD_CAP));
      r_sram_rd <= (w_next != S_WR_DO);
      r_wr_done <= (w_next == S_WR_HOLD);
    end
  end

  // Read capture, response pulse and completion counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= {DATA_W{1'b0}};
      r_wr_cnt    <= 16'd0;
      r_rd_cnt    <= 16'd0;
    end else begin
      r_rsp_valid <= (r_state == S_RD_CAP);
      if (r_state == S_RD_CAP) begin
        r_rsp_data <= sramData;
        r_rd_cnt   <= r_rd_cnt + 16'd1;
      end
      if (r_state == S_WR_HOLD) begin
        r_wr_cnt <= r_wr_cnt + 16'd1;
      end
    end
  end

  assign sramData     = r_drive ? r_wdata : {DATA_W{1'bz}};
  assign reqReady     = ~r_buf_full;
  assign rspValid     = r_rsp_valid;
  assign rspData      = r_rsp_data;
  assign wrDone       = r_wr_done;
  assign sramAdrx     = r_adrx;
  assign sramNotOutEn = r_oe_n;
  assign sramRead     = r_sram_rd;
  assign wrCount      = r_wr_cnt;
  assign rdCount      = r_rd_cnt;

endmodule

// File: doc/sram_port_ctrl.md
SRAM_PORT_CTRL -- requirements
Module: sram_port_ctrl

Interface
REQ-001 Parameter ADRX_W, default 11, SRAM word-address width.
REQ-002 Parameter DATA_W, default 32, SRAM/bus data width.
REQ-003 Parameter RD_LAT, default 1, range 1-7, cycles from sramNotOutEn low to SRAM data valid.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 reqValid  in  1  requester presents an access.
REQ-007 reqReady  out  1  controller can accept; a transfer occurs when reqValid & reqReady at a rising edge.
REQ-008 reqWrite  in  1  1 = write, 0 = read.
REQ-009 reqAdrx  in  ADRX_W  word address.
REQ-010 reqData  in  DATA_W  write data.
REQ-011 rspValid  out  1  one-cycle pulse, rspData valid.
REQ-012 rspData  out  DATA_W  read data, held until next read completes.
REQ-013 wrDone  out  1  one-cycle pulse on write completion.
REQ-014 sramAdrx  out  ADRX_W  SRAM address.
REQ-015 sramData  inout  DATA_W  shared tri-state data bus.
REQ-016 sramNotOutEn  out  1  active-low SRAM output enable.
REQ-017 sramRead  out  1  SRAM write strobe, 1 = read/idle, 0 = write.
REQ-018 wrCount, rdCount  out  16 each  completed-access counters, wrapping.

Function
REQ-019 One-entry request buffer; reqReady SHALL equal ~bufFull, independent of FSM state.
REQ-020 Accepted request SHALL load the buffer (adrx, data, write flag) at that edge.
REQ-021 FSM states: IDLE, WR_SET, WR_DO, WR_HOLD, RD_EN, RD_CAP.
REQ-022 IDLE with bufFull SHALL move the buffer into working registers, clear bufFull, and go to WR_SET (write) or RD_EN (read); IDLE without bufFull SHALL stay.
REQ-023 WR_SET: sramAdrx = working adrx, bus driven with working data, sramRead=1, sramNotOutEn=1; next WR_DO.
REQ-024 WR_DO: bus driven, sramRead=0 for exactly one cycle; next WR_HOLD.
REQ-025 WR_HOLD: bus driven, sramRead=1, wrDone=1, wrCount increments; next IDLE.
REQ-026 RD_EN: bus released (z), sramNotOutEn=0; stays RD_LAT cycles (3-bit counter), then RD_CAP.
REQ-027 RD_CAP: sramNotOutEn=0; rspData SHALL capture sramData at the edge ending RD_CAP; rspValid=1 the following cycle; rdCount increments; next IDLE.
REQ-028 sramData SHALL be driven only in WR_SET/WR_DO/WR_HOLD and never while sramNotOutEn=0; every write follows at least one IDLE cycle after a read (bus turnaround).
REQ-029 sramRead SHALL never be 0 outside WR_DO; sramAdrx SHALL be stable from WR_SET through WR_HOLD and throughout RD_EN/RD_CAP.
REQ-030 Latency from accept edge T: write strobe in cycle T+3, wrDone in T+4; read rspValid in T+3+RD_LAT.
REQ-031 A new request MAY be accepted while an access is in progress; it SHALL start on the next IDLE, preserving order.
REQ-032 Counters SHALL wrap 16'hFFFF -> 0.
REQ-033 All sram outputs and pulses SHALL be Moore decodes of registered state (glitch-free).

Reset
REQ-034 rst=0 SHALL immediately force: state IDLE, bufFull 0, reqReady 1 after release, rspValid 0, wrDone 0, rspData 0, counters 0, sramAdrx 0, sramRead 1, sramNotOutEn 1, bus z.
REQ-035 Reset mid-access SHALL abort it with no write strobe and no pulse; buffered request is discarded.

Verification
REQ-036 Write adrx 11'h005 data 32'h0000007F -> strobe T+3 with bus=7F, sramAdrx=005; wrDone T+4; wrCount=1.
REQ-037 Read 11'h005 after REQ-036 (SRAM model, RD_LAT=1) -> sramNotOutEn low 2 cycles; rspData=32'h7F, rspValid at T+4.
REQ-038 Back-to-back: write 0x010, read 0x010 presented continuously -> second accepted once buffer frees, read returns written value, one IDLE gap, no contention cycle.
REQ-039 reqValid held 4 writes continuously -> reqReady drops while buffered; 4 strobes, order and addresses preserved, wrCount=4.
REQ-040 rst=0 asserted during WR_SET -> no strobe, bus z same cycle, counters 0, reqReady=1 after release.
REQ-041 RD_LAT=3, read 0x7FF -> RD_EN 3 cycles, rspValid at T+6, address held throughout.
